regfile_sb: RTL and testbench

//  Parametrised integer register file for the pipelined core: NRD registered read ports, one write port,
//  per-register busy scoreboard for hazard detection, and a sequential clear engine after reset
//  (one register per cycle, so no wide reset fan-out). Sits between decode (reads/issue) and writeback.

---
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with NRD registered read ports, one write port, busy scoreboard and a
// one-register-per-cycle clear engine after reset. Define REGFILE_FWD_EN for write-first reads.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic                i_rd_write,
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [XLEN-1:0]     i_rd_data,
    input  logic                i_issue_valid,
    input  logic [AW-1:0]       i_issue_addr,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]      o_rs_busy,
    output logic                o_ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_ctr;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic            wr_ok;
    logic            iss_ok;
    logic [AW-1:0]   rs_a   [NRD];
    logic [XLEN-1:0] rd_val [NRD];

    always_comb begin
        wr_ok  = i_rd_write && (i_rd_addr != '0);
        iss_ok = i_issue_valid && (i_issue_addr != '0);
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[i_rd_addr] = 1'b0;
        // Set after clear: a newer producer issuing this cycle keeps the register busy.
        if (iss_ok)
            busy_nxt[i_issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rs_a[k]   = i_rs_addr[k*AW +: AW];
            rd_val[k] = regs[rs_a[k]];
`ifdef REGFILE_FWD_EN
            if (wr_ok && (rs_a[k] == i_rd_addr))
                rd_val[k] = i_rd_data;
`endif
            if (rs_a[k] == '0)
                rd_val[k] = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= CLEAR;
            clr_ctr   <= '0;
            busy      <= '0;
            o_rs_data <= '0;
            o_rs_busy <= '0;
            o_ready   <= 1'b0;
        end else if (i_clk_en) begin
            case (state)
                CLEAR: begin
                    regs[clr_ctr] <= '0;
                    clr_ctr       <= clr_ctr + 1'b1;
                    o_rs_data     <= '0;
                    o_rs_busy     <= '0;
                    if (clr_ctr == AW'(NREGS - 1)) begin
                        state   <= RUN;
                        o_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_ok)
                        regs[i_rd_addr] <= i_rd_data;
                    busy <= busy_nxt;
                    for (int unsigned k = 0; k < NRD; k++) begin
                        o_rs_data[k*XLEN +: XLEN] <= rd_val[k];
                        o_rs_busy[k]              <= busy_nxt[rs_a[k]];
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb against an array-based reference model, plus directed literal checks.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b1;
    logic                wr = 1'b0;
    logic [AW-1:0]       wa = '0;
    logic [XLEN-1:0]     wd = '0;
    logic                iss = 1'b0;
    logic [AW-1:0]       ia = '0;
    logic [NRD*AW-1:0]   rs = '0;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                ready;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(en),
        .i_rd_write(wr), .i_rd_addr(wa), .i_rd_data(wd),
        .i_issue_valid(iss), .i_issue_addr(ia),
        .i_rs_addr(rs), .o_rs_data(rs_data), .o_rs_busy(rs_busy), .o_ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents, busy set, and count of enabled clear cycles.
    logic [XLEN-1:0]     mem [NREGS];
    bit                  mbusy [NREGS];
    int                  clr_cnt = 0;
    bit                  started = 1'b0;
    logic [NRD*XLEN-1:0] exp_data;
    logic [NRD-1:0]      exp_busy;
    logic                exp_ready;

`ifdef REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nb [NREGS];
        int a;
        if (rst) begin
            clr_cnt = 0;
            foreach (mem[i]) mem[i] = '0;
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            exp_data  = '0;
            exp_busy  = '0;
            exp_ready = 1'b0;
            started   = 1'b1;
        end else if (started && en) begin
            if (clr_cnt < NREGS) begin
                clr_cnt++;
                exp_data  = '0;
                exp_busy  = '0;
                exp_ready = (clr_cnt == NREGS);
            end else begin
                nb = mbusy;
                if (wr && wa != 0) nb[wa] = 1'b0;
                if (iss && ia != 0) nb[ia] = 1'b1;
                for (int k = 0; k < NRD; k++) begin
                    a = int'(rs[k*AW +: AW]);
                    if (a == 0)
                        exp_data[k*XLEN +: XLEN] = '0;
                    else if (FWD && wr && a == int'(wa))
                        exp_data[k*XLEN +: XLEN] = wd;
                    else
                        exp_data[k*XLEN +: XLEN] = mem[a];
                    exp_busy[k] = nb[a];
                end
                if (wr && wa != 0) mem[wa] = wd;
                mbusy = nb;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", 64'(ready), 64'(exp_ready));
            chk("rs_data", 64'(rs_data), 64'(exp_data));
            chk("rs_busy", 64'(rs_busy), 64'(exp_busy));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        wr = 1'b0; iss = 1'b0; wa = '0; wd = '0; ia = '0; en = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 1; i <= NREGS; i++) begin
            cyc();
            if (i == NREGS - 1) chk({tag, "_ready_low"}, 64'(ready), 64'(0));
            if (i == NREGS)     chk({tag, "_ready_high"}, 64'(ready), 64'(1));
        end
    endtask

    initial begin
        logic [XLEN-1:0] dead;
        dead = 32'hDEADBEEF;
        idle();
        rs = '0;
        cyc();
        rst = 1'b0;
        chk("reset_ready", 64'(ready), 64'(0));
        wait_ready("clear1");

        // write then read x5, x0 ignored
        wr = 1'b1; wa = 5; wd = dead; cyc();
        wr = 1'b0; rs[0 +: AW] = 5; cyc();
        chk("x5_read", 64'(rs_data[0 +: XLEN]), 64'(dead));
        wr = 1'b1; wa = 0; wd = 32'h1234; cyc();
        wr = 1'b0; rs[0 +: AW] = 0; cyc();
        chk("x0_read", 64'(rs_data[0 +: XLEN]), 64'(0));

        // same-cycle write/read on x7
        wr = 1'b1; wa = 7; wd = 32'hA5A5A5A5; rs[AW +: AW] = 7; cyc();
        chk("x7_same_cycle", 64'(rs_data[XLEN +: XLEN]), FWD ? 64'(32'hA5A5A5A5) : 64'(0));
        wr = 1'b0; cyc();
        chk("x7_next", 64'(rs_data[XLEN +: XLEN]), 64'(32'hA5A5A5A5));

        // scoreboard on x3
        iss = 1'b1; ia = 3; rs[0 +: AW] = 3; cyc();
        chk("x3_issue_busy", 64'(rs_busy[0]), 64'(1));
        iss = 1'b0; wr = 1'b1; wa = 3; wd = 32'h33; cyc();
        chk("x3_wb_free", 64'(rs_busy[0]), 64'(0));
        iss = 1'b1; ia = 3; cyc();
        chk("x3_both_busy", 64'(rs_busy[0]), 64'(1));

        // stall during a write: nothing moves
        idle(); rs[0 +: AW] = 9; cyc();
        chk("x9_pre", 64'(rs_data[0 +: XLEN]), 64'(0));
        en = 1'b0; wr = 1'b1; wa = 9; wd = 32'h55; iss = 1'b1; ia = 9; rs[0 +: AW] = 3; cyc(3);
        chk("stall_data_hold", 64'(rs_data[0 +: XLEN]), 64'(0));
        chk("stall_busy_hold", 64'(rs_busy[0]), 64'(0));
        idle(); rs[0 +: AW] = 9; cyc();
        chk("x9_unwritten", 64'(rs_data[0 +: XLEN]), 64'(0));
        chk("x9_not_busy", 64'(rs_busy[0]), 64'(0));

        // reset mid-clear with a stall inside the clear
        rst = 1'b1; cyc(); rst = 1'b0;
        cyc(5);
        en = 1'b0; cyc(6);
        chk("stall_clear_ready", 64'(ready), 64'(0));
        en = 1'b1; cyc(5);
        rst = 1'b1; cyc(); rst = 1'b0;
        wait_ready("clear2");
        rs[0 +: AW] = 3; rs[AW +: AW] = 5; cyc();
        chk("x3_busy_after_reset", 64'(rs_busy[0]), 64'(0));
        chk("x5_cleared", 64'(rs_data[XLEN +: XLEN]), 64'(0));

        // randomised traffic, biased toward a few low registers to create collisions
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 7) != 0);
            wr  = $urandom_range(0, 1);
            iss = $urandom_range(0, 2) == 0;
            wa  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ia  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wd  = $urandom;
            for (int k = 0; k < NRD; k++)
                rs[k*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
